fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000: fetch address loaded at reset.
REQ-002 Parameter PC_INCREMENT, default 4: sequential PC step.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port stall_i  input  1  decode stage does not consume the IF/ID entry this cycle.
REQ-006 Port redirect_i  input  1  taken branch/jump/jr; flushes fetch and IF/ID.
REQ-007 Port redirect_pc_i  input  32  redirect target address.
REQ-008 Port imem_req_o  output  1  instruction memory request.
REQ-009 Port imem_addr_o  output  32  instruction memory byte address.
REQ-010 Port imem_ack_i  input  1  memory returns imem_rdata_i for current request.
REQ-011 Port imem_rdata_i  input  32  fetched instruction word.
REQ-012 Port if_id_valid_o  output  1  IF/ID entry holds a live instruction.
REQ-013 Port if_id_pc_o  output  32  address of IF/ID instruction.
REQ-014 Port if_id_pc_plus4_o  output  32  if_id_pc_o + PC_INCREMENT.
REQ-015 Port if_id_instr_o  output  32  IF/ID instruction word.
REQ-016 Port addr_err_o  output  1  sticky flag: misaligned redirect target seen.

Function
REQ-017 FSM states SHALL be FETCH, HOLD, DROP; PC register pc drives imem_addr_o in FETCH and DROP.
REQ-018 Memory protocol: once imem_req_o=1, imem_req_o and imem_addr_o SHALL stay stable until the cycle imem_ack_i=1; ack arrives 1+ cycles after req; ack when req=0 is ignored.
REQ-019 FETCH: imem_req_o=1; IF/ID can accept when stall_i=0 or if_id_valid_o=0.
REQ-020 FETCH, ack, IF/ID can accept: load IF/ID {pc, pc+PC_INCREMENT, imem_rdata_i}, valid=1, pc<=pc+PC_INCREMENT, stay FETCH (throughput 1 instr/cycle with 1-cycle ack).
REQ-021 FETCH, ack, IF/ID cannot accept: capture word and pc into hold buffer, pc<=pc+PC_INCREMENT, go HOLD.
REQ-022 FETCH, no ack, IF/ID consumed (stall_i=0): if_id_valid_o<=0.
REQ-023 HOLD: imem_req_o=0; IF/ID unchanged while stall_i=1; when stall_i=0 load IF/ID from hold buffer, valid=1, go FETCH.
REQ-024 DROP: imem_req_o=1 at old address; on ack discard data, pc<=pending_pc, go FETCH; if_id_valid_o=0 throughout.
REQ-025 Redirect has top priority over stall and ack, in every state: if_id_valid_o<=0, if_id_instr_o<=0, hold buffer discarded.
REQ-026 Redirect in FETCH without ack same cycle: pending_pc<=target, go DROP; with ack same cycle: data discarded, pc<=target, stay FETCH.
REQ-027 Redirect in HOLD: pc<=target, go FETCH; in DROP: pending_pc<=target (latest wins), stay DROP.
REQ-028 Target used SHALL be {redirect_pc_i[31:2],2'b00}; redirect_pc_i[1:0]!=0 sets addr_err_o=1 until reset.
REQ-029 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0, no flag.
REQ-030 if_id_valid_o=0 implies if_id_instr_o holds last loaded or flushed value; consumers use valid only.

Reset
REQ-031 reset=0 SHALL asynchronously set pc=RESET_PC, state=FETCH, if_id_valid_o=0, if_id_pc_o=0, if_id_pc_plus4_o=0, if_id_instr_o=0, addr_err_o=0, hold buffer and pending_pc=0.
REQ-032 imem_req_o SHALL be 0 while reset=0; first request (addr RESET_PC) issues the cycle after deassertion.
REQ-033 Reset asserted mid-request SHALL abandon it; any ack during reset is ignored.

Verification
REQ-034 Reset release, ack every cycle, words A,B,C -> IF/ID shows (0x00400000,A),(0x00400004,B),(0x00400008,C) on consecutive cycles, valid=1.
REQ-035 stall_i=1 with valid entry, ack for word B -> state HOLD, req=0, IF/ID keeps A; stall_i=0 -> IF/ID=B at 0x00400004, next req addr 0x00400008.
REQ-036 Redirect to 0x00400100 while req outstanding at 0x00400010 (ack 3 cycles later) -> valid=0, req addr stays 0x00400010 until ack, data dropped, next req addr 0x00400100.
REQ-037 Redirect and ack same cycle with stall_i=1 -> IF/ID valid=0, instr=0, next req addr = target.
REQ-038 Redirect to 0x00400102 -> fetch at 0x00400100, addr_err_o=1 until reset.
REQ-039 Redirect to 0xFFFFFFFC, ack -> next fetch at 0x00000000, if_id_pc_plus4_o=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory request and fills
// the IF/ID register, with a one-entry hold buffer and redirect/drop handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter logic [31:0] PC_INCREMENT = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic [31:0] if_id_instr_o,
    output logic        addr_err_o
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_DROP  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        active;
    logic        ack;
    logic        can_accept;
    logic [31:0] target;
    logic [31:0] pc_next;

    // active keeps the request low until the first edge after reset release
    assign imem_req_o  = active && (state != S_HOLD);
    assign imem_addr_o = pc;
    assign ack         = imem_ack_i && imem_req_o;
    assign can_accept  = !stall_i || !if_id_valid_o;
    assign target      = {redirect_pc_i[31:2], 2'b00};
    assign pc_next     = pc + PC_INCREMENT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_FETCH;
            pc               <= RESET_PC;
            pending_pc       <= '0;
            hold_pc          <= '0;
            hold_instr       <= '0;
            active           <= 1'b0;
            if_id_valid_o    <= 1'b0;
            if_id_pc_o       <= '0;
            if_id_pc_plus4_o <= '0;
            if_id_instr_o    <= '0;
            addr_err_o       <= 1'b0;
        end else begin
            active <= 1'b1;
            if (redirect_i && (redirect_pc_i[1:0] != 2'b00))
                addr_err_o <= 1'b1;

            if (redirect_i) begin
                if_id_valid_o <= 1'b0;
                if_id_instr_o <= '0;
                hold_pc       <= '0;
                hold_instr    <= '0;
                // an outstanding request must complete before the target is fetched
                if (state == S_HOLD || ack) begin
                    pc    <= target;
                    state <= S_FETCH;
                end else begin
                    pending_pc <= target;
                    state      <= S_DROP;
                end
            end else begin
                unique case (state)
                    S_FETCH: begin
                        if (ack && can_accept) begin
                            if_id_valid_o    <= 1'b1;
                            if_id_pc_o       <= pc;
                            if_id_pc_plus4_o <= pc_next;
                            if_id_instr_o    <= imem_rdata_i;
                            pc               <= pc_next;
                        end else if (ack) begin
                            hold_pc    <= pc;
                            hold_instr <= imem_rdata_i;
                            pc         <= pc_next;
                            state      <= S_HOLD;
                        end else if (!stall_i) begin
                            if_id_valid_o <= 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (!stall_i) begin
                            if_id_valid_o    <= 1'b1;
                            if_id_pc_o       <= hold_pc;
                            if_id_pc_plus4_o <= hold_pc + PC_INCREMENT;
                            if_id_instr_o    <= hold_instr;
                            state            <= S_FETCH;
                        end
                    end
                    S_DROP: begin
                        if (ack) begin
                            pc    <= pending_pc;
                            state <= S_FETCH;
                        end
                    end
                    default: state <= S_FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit plus hand-written sequences
// for hold/redirect interaction and asynchronous reset.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc_plus4_o;
    logic [31:0] if_id_instr_o;
    logic        addr_err_o;

    int checks = 0;
    int passed = 0;

    fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ack_i       (imem_ack_i),
        .imem_rdata_i     (imem_rdata_i),
        .if_id_valid_o    (if_id_valid_o),
        .if_id_pc_o       (if_id_pc_o),
        .if_id_pc_plus4_o (if_id_pc_plus4_o),
        .if_id_instr_o    (if_id_instr_o),
        .addr_err_o       (addr_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic st, input logic rd, input logic [31:0] rp,
        input logic ak, input logic [31:0] dt,
        input logic rq, input logic [31:0] ad, input logic vl,
        input logic [31:0] p, input logic [31:0] p4,
        input logic [31:0] in, input logic er);
        vec_t v;
        v.stall = st; v.redir = rd; v.rpc = rp; v.ack = ak; v.rdata = dt;
        v.e_req = rq; v.e_addr = ad; v.e_valid = vl; v.e_pc = p;
        v.e_pc4 = p4; v.e_instr = in; v.e_err = er;
        return v;
    endfunction

    task automatic check_out(input string name, input vec_t v);
        logic [130:0] act;
        logic [130:0] exp;
        act = {imem_req_o, imem_addr_o, if_id_valid_o, if_id_pc_o,
               if_id_pc_plus4_o, if_id_instr_o, addr_err_o};
        exp = {v.e_req, v.e_addr, v.e_valid, v.e_pc,
               v.e_pc4, v.e_instr, v.e_err};
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got req=%b addr=%h v=%b pc=%h pc4=%h ins=%h err=%b want req=%b addr=%h v=%b pc=%h pc4=%h ins=%h err=%b",
                name, act[130], act[129:98], act[97], act[96:65], act[64:33],
                act[32:1], act[0], exp[130], exp[129:98], exp[97], exp[96:65],
                exp[64:33], exp[32:1], exp[0]);
    endtask

    task automatic run(input string name, input vec_t v);
        stall_i       = v.stall;
        redirect_i    = v.redir;
        redirect_pc_i = v.rpc;
        imem_ack_i    = v.ack;
        imem_rdata_i  = v.rdata;
        @(posedge clk);
        #1;
        check_out(name, v);
    endtask

    localparam logic [31:0] RP  = 32'h0040_0000;
    localparam logic [31:0] WA  = 32'hAAAA_0001;
    localparam logic [31:0] WB  = 32'hBBBB_0002;
    localparam logic [31:0] WC  = 32'hCCCC_0003;
    localparam logic [31:0] WD  = 32'hDDDD_0004;
    localparam logic [31:0] WE  = 32'hEEEE_0005;
    localparam logic [31:0] WH  = 32'h1234_5678;
    localparam logic [31:0] WI  = 32'h9ABC_DEF0;
    localparam logic [31:0] WJ  = 32'h0BAD_F00D;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    initial begin
        reset = 1'b0; stall_i = 0; redirect_i = 0; redirect_pc_i = '0;
        imem_ack_i = 0; imem_rdata_i = '0;

        // stall r  rpc           ack data  req addr          v pc            pc4           instr err
        tbl.push_back(mk(0,0,32'h0,        0,'0,   1,RP,           0,32'h0,        32'h0,        32'h0,0));
        tbl.push_back(mk(0,0,32'h0,        1,WA,   1,32'h00400004, 1,32'h00400000, 32'h00400004, WA,0));
        tbl.push_back(mk(0,0,32'h0,        1,WB,   1,32'h00400008, 1,32'h00400004, 32'h00400008, WB,0));
        tbl.push_back(mk(0,0,32'h0,        1,WC,   1,32'h0040000C, 1,32'h00400008, 32'h0040000C, WC,0));
        tbl.push_back(mk(1,0,32'h0,        1,WD,   0,32'h00400010, 1,32'h00400008, 32'h0040000C, WC,0));
        tbl.push_back(mk(1,0,32'h0,        1,BAD,  0,32'h00400010, 1,32'h00400008, 32'h0040000C, WC,0));
        tbl.push_back(mk(0,0,32'h0,        0,'0,   1,32'h00400010, 1,32'h0040000C, 32'h00400010, WD,0));
        tbl.push_back(mk(0,0,32'h0,        0,'0,   1,32'h00400010, 0,32'h0040000C, 32'h00400010, WD,0));
        tbl.push_back(mk(0,1,32'h00400100, 0,'0,   1,32'h00400010, 0,32'h0040000C, 32'h00400010, 32'h0,0));
        tbl.push_back(mk(0,0,32'h0,        0,'0,   1,32'h00400010, 0,32'h0040000C, 32'h00400010, 32'h0,0));
        tbl.push_back(mk(0,0,32'h0,        1,BAD,  1,32'h00400100, 0,32'h0040000C, 32'h00400010, 32'h0,0));
        tbl.push_back(mk(0,0,32'h0,        1,WE,   1,32'h00400104, 1,32'h00400100, 32'h00400104, WE,0));
        tbl.push_back(mk(1,1,32'h00400200, 1,BAD,  1,32'h00400200, 0,32'h00400100, 32'h00400104, 32'h0,0));
        tbl.push_back(mk(0,1,32'h00400102, 0,'0,   1,32'h00400200, 0,32'h00400100, 32'h00400104, 32'h0,1));
        tbl.push_back(mk(0,0,32'h0,        1,BAD,  1,32'h00400100, 0,32'h00400100, 32'h00400104, 32'h0,1));
        tbl.push_back(mk(0,0,32'h0,        1,WH,   1,32'h00400104, 1,32'h00400100, 32'h00400104, WH,1));
        tbl.push_back(mk(0,1,32'hFFFFFFFC, 1,BAD,  1,32'hFFFFFFFC, 0,32'h00400100, 32'h00400104, 32'h0,1));
        tbl.push_back(mk(0,0,32'h0,        1,WI,   1,32'h00000000, 1,32'hFFFFFFFC, 32'h00000000, WI,1));
        tbl.push_back(mk(0,0,32'h0,        1,WJ,   1,32'h00000004, 1,32'h00000000, 32'h00000004, WJ,1));

        repeat (3) @(posedge clk);
        #1;
        check_out("reset_state", mk(0,0,0,0,0, 0,RP,0,0,0,0,0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_out("req_low_after_release", mk(0,0,0,0,0, 0,RP,0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++)
            run($sformatf("row%0d", i), tbl[i]);

        // hold buffer is discarded by a redirect in HOLD
        run("hold_enter", mk(1,0,0,1,BAD, 0,32'h8,1,32'h0,32'h4,WJ,1));
        run("hold_redirect", mk(1,1,32'h00400300,0,0, 1,32'h00400300,0,32'h0,32'h4,32'h0,1));
        run("hold_not_replayed", mk(0,0,0,0,0, 1,32'h00400300,0,32'h0,32'h4,32'h0,1));

        // asynchronous reset mid-request, ack during reset ignored
        imem_ack_i = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_out("async_reset", mk(0,0,0,0,0, 0,RP,0,0,0,0,0));
        imem_ack_i = 1'b1; imem_rdata_i = BAD;
        @(posedge clk);
        #1;
        check_out("ack_in_reset", mk(0,0,0,0,0, 0,RP,0,0,0,0,0));
        imem_ack_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_out("release2", mk(0,0,0,0,0, 0,RP,0,0,0,0,0));
        run("first_req2", mk(0,0,0,0,0, 1,RP,0,0,0,0,0));
        run("first_fetch2", mk(0,0,0,1,WA, 1,32'h00400004,1,RP,32'h00400004,WA,0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
